// File: rtl/cache_pkg.sv
// Shared sizes and the controller state encoding for the cache request sequencer.
package cache_pkg;

  localparam int unsigned CACHE_ADDR_INDEX_SIZE = 6;
  localparam int unsigned CACHE_ADDR_TAG_SIZE   = 6;
  localparam int unsigned CACHE_CHANNEL_SIZE    = 3;
  localparam int unsigned CACHE_STAT_SIZE       = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_FILL      = 3'd2,
    ST_LOAD      = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_WRITE_MEM = 3'd5,
    ST_RESP      = 3'd6
  } cache_state_e;

  // States in which a main-memory transfer is outstanding.
  function automatic logic is_mem_state(input cache_state_e s);
    return (s == ST_FILL) || (s == ST_WRITE_MEM);
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, tag-memory and main-memory signal bundle of the cache controller.
// master = controller side, slave = CPU / tag memory / main memory side.
interface cache_controller_if #(
  parameter int c_ADDR_INDEX_SIZE = 6,
  parameter int c_ADDR_TAG_SIZE   = 6,
  parameter int c_CHANNEL_SIZE    = 3
) ();

  logic                                       CPU_REQ;
  logic                                       CPU_WE;
  logic [c_ADDR_TAG_SIZE+c_ADDR_INDEX_SIZE-1:0] CPU_ADDR;
  logic                                       CPU_READY;
  logic                                       CPU_HIT;
  logic [c_CHANNEL_SIZE-1:0]                  CPU_CHANNEL;

  logic [c_ADDR_INDEX_SIZE-1:0]               ADDR_INDEX;
  logic [c_ADDR_TAG_SIZE-1:0]                 ADDR_TAG;
  logic                                       SIG_LRU;
  logic                                       SIG_LOAD;
  logic                                       HIT;
  logic [c_CHANNEL_SIZE-1:0]                  CHANNEL;

  logic                                       MEM_REQ;
  logic                                       MEM_WE;
  logic                                       MEM_ACK;

  modport master (
    input  CPU_REQ, CPU_WE, CPU_ADDR, HIT, CHANNEL, MEM_ACK,
    output CPU_READY, CPU_HIT, CPU_CHANNEL, ADDR_INDEX, ADDR_TAG,
           SIG_LRU, SIG_LOAD, MEM_REQ, MEM_WE
  );

  modport slave (
    output CPU_REQ, CPU_WE, CPU_ADDR, HIT, CHANNEL, MEM_ACK,
    input  CPU_READY, CPU_HIT, CPU_CHANNEL, ADDR_INDEX, ADDR_TAG,
           SIG_LRU, SIG_LOAD, MEM_REQ, MEM_WE
  );

endinterface

// File: rtl/cache_stat_counter.sv
// Saturating event counter for the hit/miss statistics.
// Only built when CACHE_CTRL_STATS_EN is defined.
`ifdef CACHE_CTRL_STATS_EN
module cache_stat_counter #(
  parameter int c_STAT_SIZE = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   inc,
  output logic [c_STAT_SIZE-1:0] count
);

  logic [c_STAT_SIZE-1:0] count_reg;

  // Holds at all-ones once reached instead of wrapping back to zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + c_STAT_SIZE'(1);
    end
  end

  assign count = count_reg;

endmodule
`endif

// File: rtl/cache_controller.sv
// Request sequencer for the set-associative cache: hit/miss resolution, fill and write-through.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller
  import cache_pkg::*;
#(
  parameter int c_ADDR_INDEX_SIZE = CACHE_ADDR_INDEX_SIZE,
  parameter int c_ADDR_TAG_SIZE   = CACHE_ADDR_TAG_SIZE,
  parameter int c_CHANNEL_SIZE    = CACHE_CHANNEL_SIZE
`ifdef CACHE_CTRL_STATS_EN
  ,
  parameter int c_STAT_SIZE       = CACHE_STAT_SIZE
`endif
) (
  input logic                CLK,
  input logic                RESET_N,
  cache_controller_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [c_STAT_SIZE-1:0] HIT_COUNT,
  output logic [c_STAT_SIZE-1:0] MISS_COUNT
`endif
);

  localparam int ADDR_SIZE = c_ADDR_TAG_SIZE + c_ADDR_INDEX_SIZE;

  cache_state_e                 state_reg, state_next;
  logic [c_ADDR_INDEX_SIZE-1:0] index_reg, index_next;
  logic [c_ADDR_TAG_SIZE-1:0]   tag_reg, tag_next;
  logic                         we_reg, we_next;
  logic                         hit_reg, hit_next;
  logic [c_CHANNEL_SIZE-1:0]    chan_reg, chan_next;

  logic                         sig_lru;
  logic                         sig_load;
  logic                         mem_req;
  logic                         mem_we;
  logic                         cpu_ready;
  logic                         cpu_hit;
  logic [c_CHANNEL_SIZE-1:0]    cpu_channel;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_IDLE;
      index_reg <= '0;
      tag_reg   <= '0;
      we_reg    <= 1'b0;
      hit_reg   <= 1'b0;
      chan_reg  <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      tag_reg   <= tag_next;
      we_reg    <= we_next;
      hit_reg   <= hit_next;
      chan_reg  <= chan_next;
    end
  end

  // Outputs decode from the state register alone, so an asynchronous reset
  // drops MEM_REQ and every strobe without waiting for a clock edge.
  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    tag_next    = tag_reg;
    we_next     = we_reg;
    hit_next    = hit_reg;
    chan_next   = chan_reg;
    sig_lru     = 1'b0;
    sig_load    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    cpu_ready   = 1'b0;
    cpu_hit     = 1'b0;
    cpu_channel = '0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.CPU_REQ) begin
          we_next    = bus.CPU_WE;
          tag_next   = bus.CPU_ADDR[ADDR_SIZE-1 -: c_ADDR_TAG_SIZE];
          index_next = bus.CPU_ADDR[c_ADDR_INDEX_SIZE-1:0];
          hit_next   = 1'b0;
          chan_next  = '0;
          state_next = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (bus.HIT) begin
          hit_next   = 1'b1;
          chan_next  = bus.CHANNEL;
          state_next = ST_UPDATE;
        end else if (we_reg) begin
          state_next = ST_WRITE_MEM;
        end else begin
          state_next = ST_FILL;
        end
      end

      ST_FILL: begin
        mem_req = 1'b1;
        if (bus.MEM_ACK) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        sig_load   = 1'b1;
        state_next = ST_UPDATE;
      end

      ST_UPDATE: begin
        sig_lru = 1'b1;
        // After a fill the tag memory only now reports the allocated way.
        if (!hit_reg) begin
          chan_next = bus.CHANNEL;
        end
        // Write misses never allocate, so a write here is always a hit.
        state_next = we_reg ? ST_WRITE_MEM : ST_RESP;
      end

      ST_WRITE_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.MEM_ACK) begin
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        cpu_ready   = 1'b1;
        cpu_hit     = hit_reg;
        cpu_channel = chan_reg;
        state_next  = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.ADDR_INDEX  = index_reg;
  assign bus.ADDR_TAG    = tag_reg;
  assign bus.SIG_LRU     = sig_lru;
  assign bus.SIG_LOAD    = sig_load;
  assign bus.MEM_REQ     = mem_req;
  assign bus.MEM_WE      = mem_we;
  assign bus.CPU_READY   = cpu_ready;
  assign bus.CPU_HIT     = cpu_hit;
  assign bus.CPU_CHANNEL = cpu_channel;

`ifdef CACHE_CTRL_STATS_EN
  // Slot 0 counts hits, slot 1 counts misses, both judged in the LOOKUP cycle.
  logic [1:0]             stat_inc;
  logic [c_STAT_SIZE-1:0] stat_count [2];

  assign stat_inc[0] = (state_reg == ST_LOOKUP) &&  bus.HIT;
  assign stat_inc[1] = (state_reg == ST_LOOKUP) && !bus.HIT;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      cache_stat_counter #(
        .c_STAT_SIZE (c_STAT_SIZE)
      ) u_stat_counter (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (stat_inc[gi]),
        .count   (stat_count[gi])
      );
    end
  endgenerate

  assign HIT_COUNT  = stat_count[0];
  assign MISS_COUNT = stat_count[1];
`endif

endmodule
